// File: rtl/drec_pkg.sv
// Shared definitions for the recorder SDRAM arbiter: FSM state encoding and command direction constants.
package drec_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } drec_state_e;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;
endpackage

// File: rtl/drec_sdram_arbiter_if.sv
// Bundle of recorder-side and SDRAM-side signals around the arbiter; slave is the arbiter's view.
interface drec_sdram_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 16
);
  logic          wr_enable;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_enable;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_rdy;
  logic          rd_data_ack;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          overrun;
  logic          rd_timeout;

  modport slave (
    input  wr_enable, wr_addr, wr_data, rd_enable, rd_addr, rd_data_ack,
           cmd_ready, rsp_valid, rsp_data,
    output rd_data, rd_data_rdy, cmd_valid, cmd_we, cmd_addr, cmd_wdata,
           overrun, rd_timeout
  );

  modport master (
    output wr_enable, wr_addr, wr_data, rd_enable, rd_addr, rd_data_ack,
           cmd_ready, rsp_valid, rsp_data,
    input  rd_data, rd_data_rdy, cmd_valid, cmd_we, cmd_addr, cmd_wdata,
           overrun, rd_timeout
  );
endinterface

// File: rtl/drec_arb_slot.sv
// One-deep pending request register. A clear and a new capture in the same cycle leave the slot full
// with the new request; a capture into a full slot that is not being cleared is dropped.
module drec_arb_slot #(
  parameter int AW = 24,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          clr,
  output logic          full,
  output logic [AW-1:0] q_addr,
  output logic [DW-1:0] q_data,
  output logic          drop
);
  assign drop = en & full & ~clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full   <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
    end else if (en && (!full || clr)) begin
      full   <= 1'b1;
      q_addr <= addr;
      q_data <= data;
    end else if (clr) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/drec_sdram_arbiter.sv
// Arbitrates record writes and play reads onto the single SDRAM command port, writes first.
// Defining DREC_ARB_STATS_EN adds saturating drop/timeout counters as extra outputs.
module drec_sdram_arbiter
  import drec_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int RD_TMO = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  drec_sdram_arbiter_if.slave  bus
`ifdef DREC_ARB_STATS_EN
  ,
  output logic [15:0]          wr_drop_cnt,
  output logic [15:0]          rd_drop_cnt,
  output logic [15:0]          tmo_cnt
`endif
);
  logic          wr_full, rd_full, wr_drop, rd_drop, wr_clr, rd_clr;
  logic [AW-1:0] wr_q_addr, rd_q_addr;
  logic [DW-1:0] wr_q_data, rd_q_data;

  drec_state_e   state, state_nxt;
  logic          we_q, we_nxt;
  logic          cmd_valid, tmo_load, tmo_hit, rsp_take;
  logic [7:0]    tmo_left;
  logic [DW-1:0] rd_data_q;
  logic          rdy_q, overrun_q, rd_timeout_q;

  drec_arb_slot #(.AW(AW), .DW(DW)) u_wr_slot (
    .clk(clk), .rst_n(rst_n), .en(bus.wr_enable), .addr(bus.wr_addr), .data(bus.wr_data),
    .clr(wr_clr), .full(wr_full), .q_addr(wr_q_addr), .q_data(wr_q_data), .drop(wr_drop)
  );

  drec_arb_slot #(.AW(AW), .DW(DW)) u_rd_slot (
    .clk(clk), .rst_n(rst_n), .en(bus.rd_enable), .addr(bus.rd_addr), .data('0),
    .clr(rd_clr), .full(rd_full), .q_addr(rd_q_addr), .q_data(rd_q_data), .drop(rd_drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we_nxt    = we_q;
    cmd_valid = 1'b0;
    wr_clr    = 1'b0;
    rd_clr    = 1'b0;
    tmo_load  = 1'b0;
    tmo_hit   = 1'b0;
    rsp_take  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_full) begin
          we_nxt    = CMD_WR;
          state_nxt = ST_ISSUE;
        end else if (rd_full && !rdy_q) begin
          we_nxt    = CMD_RD;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cmd_valid = 1'b1;
        if (bus.cmd_ready) begin
          if (we_q == CMD_WR) begin
            wr_clr    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            rd_clr    = 1'b1;
            tmo_load  = 1'b1;
            state_nxt = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (bus.rsp_valid) begin
          rsp_take  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_left <= 8'd1) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      tmo_left     <= 8'd0;
      rd_data_q    <= '0;
      rdy_q        <= 1'b0;
      overrun_q    <= 1'b0;
      rd_timeout_q <= 1'b0;
    end else begin
      we_q <= we_nxt;
      if (tmo_load)
        tmo_left <= 8'(RD_TMO);
      else if (state == ST_WAIT_RD && tmo_left != 8'd0)
        tmo_left <= tmo_left - 8'd1;
      if (rsp_take) begin
        rd_data_q <= bus.rsp_data;
        rdy_q     <= 1'b1;
      end else if (rdy_q && bus.rd_data_ack) begin
        rdy_q <= 1'b0;
      end
      overrun_q    <= overrun_q | wr_drop | rd_drop;
      rd_timeout_q <= rd_timeout_q | tmo_hit;
    end
  end

  // Command fields read as zero outside ISSUE so the port is quiet after reset
  assign bus.cmd_valid   = cmd_valid;
  assign bus.cmd_we      = cmd_valid & we_q;
  assign bus.cmd_addr    = cmd_valid ? (we_q ? wr_q_addr : rd_q_addr) : '0;
  assign bus.cmd_wdata   = cmd_valid ? (we_q ? wr_q_data : rd_q_data) : '0;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_data_rdy = rdy_q;
  assign bus.overrun     = overrun_q;
  assign bus.rd_timeout  = rd_timeout_q;

`ifdef DREC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_drop_cnt <= 16'd0;
      rd_drop_cnt <= 16'd0;
      tmo_cnt     <= 16'd0;
    end else begin
      if (wr_drop && wr_drop_cnt != 16'hFFFF) wr_drop_cnt <= wr_drop_cnt + 16'd1;
      if (rd_drop && rd_drop_cnt != 16'hFFFF) rd_drop_cnt <= rd_drop_cnt + 16'd1;
      if (tmo_hit && tmo_cnt != 16'hFFFF)     tmo_cnt     <= tmo_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_drec_sdram_arbiter.sv
// Directed bench for drec_sdram_arbiter: write, read/return, priority, overrun, timeout and reset cases.
module tb_drec_sdram_arbiter;
  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  drec_sdram_arbiter_if #(.AW(24), .DW(16)) bus ();

`ifdef DREC_ARB_STATS_EN
  logic [15:0] wr_drop_cnt, rd_drop_cnt, tmo_cnt;
`endif

  drec_sdram_arbiter #(.AW(24), .DW(16), .RD_TMO(255)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef DREC_ARB_STATS_EN
    , .wr_drop_cnt(wr_drop_cnt), .rd_drop_cnt(rd_drop_cnt), .tmo_cnt(tmo_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
    chk({tag, ".cmd_we"},    32'(bus.cmd_we),    32'd0);
    chk({tag, ".cmd_addr"},  32'(bus.cmd_addr),  32'd0);
    chk({tag, ".cmd_wdata"}, 32'(bus.cmd_wdata), 32'd0);
    chk({tag, ".rd_data"},   32'(bus.rd_data),   32'd0);
    chk({tag, ".rdy"},       32'(bus.rd_data_rdy), 32'd0);
    chk({tag, ".overrun"},   32'(bus.overrun),   32'd0);
    chk({tag, ".rd_tmo"},    32'(bus.rd_timeout), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_enable = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_enable = 0; bus.rd_addr = '0; bus.rd_data_ack = 0;
    bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_data = '0;
    repeat (3) tick();
    chk_quiet("reset");
    rst_n = 1'b1;

    // 1: single write, 2-cycle pulse-to-command latency, then clear+capture in the handshake cycle
    bus.cmd_ready = 1;
    bus.wr_enable = 1; bus.wr_addr = 24'h000010; bus.wr_data = 16'hA5A5;
    tick();
    bus.wr_enable = 0;
    chk("t1.valid_early", 32'(bus.cmd_valid), 32'd0);
    tick();
    chk("t1.valid", 32'(bus.cmd_valid), 32'd1);
    chk("t1.we",    32'(bus.cmd_we),    32'd1);
    chk("t1.addr",  32'(bus.cmd_addr),  32'h10);
    chk("t1.wdata", 32'(bus.cmd_wdata), 32'hA5A5);
    bus.wr_enable = 1; bus.wr_addr = 24'h000011; bus.wr_data = 16'h1111;
    tick();
    bus.wr_enable = 0;
    chk("t1.valid_after_hs", 32'(bus.cmd_valid), 32'd0);
    tick();
    chk("t1.recap_addr",  32'(bus.cmd_addr),  32'h11);
    chk("t1.recap_wdata", 32'(bus.cmd_wdata), 32'h1111);
    chk("t1.overrun",     32'(bus.overrun),   32'd0);
    tick();

    // 2: read, response 3 cycles after handshake, held until ack; second read blocked while rdy
    bus.rd_enable = 1; bus.rd_addr = 24'h000020;
    tick();
    bus.rd_enable = 0;
    tick();
    chk("t2.valid", 32'(bus.cmd_valid), 32'd1);
    chk("t2.we",    32'(bus.cmd_we),    32'd0);
    chk("t2.addr",  32'(bus.cmd_addr),  32'h20);
    tick();
    tick();
    tick();
    bus.rsp_valid = 1; bus.rsp_data = 16'h1234;
    chk("t2.rdy_before_rsp", 32'(bus.rd_data_rdy), 32'd0);
    tick();
    bus.rsp_valid = 0; bus.rsp_data = 16'h0000;
    chk("t2.rdy",  32'(bus.rd_data_rdy), 32'd1);
    chk("t2.data", 32'(bus.rd_data),     32'h1234);
    bus.rd_enable = 1; bus.rd_addr = 24'h000030;
    tick();
    bus.rd_enable = 0;
    repeat (3) tick();
    chk("t2.rdy_held",  32'(bus.rd_data_rdy), 32'd1);
    chk("t2.data_held", 32'(bus.rd_data),     32'h1234);
    chk("t2.no_issue",  32'(bus.cmd_valid),   32'd0);
    bus.rd_data_ack = 1;
    tick();
    bus.rd_data_ack = 0;
    chk("t2.rdy_after_ack", 32'(bus.rd_data_rdy), 32'd0);
    tick();
    chk("t2.rd2_valid", 32'(bus.cmd_valid), 32'd1);
    chk("t2.rd2_addr",  32'(bus.cmd_addr),  32'h30);
    tick();
    bus.rsp_valid = 1; bus.rsp_data = 16'h5555;
    tick();
    bus.rsp_valid = 0;
    chk("t2.rd2_data", 32'(bus.rd_data), 32'h5555);
    bus.rd_data_ack = 1;
    tick();
    bus.rd_data_ack = 0;

    // 3: simultaneous pulses, write wins
    bus.wr_enable = 1; bus.wr_addr = 24'h000040; bus.wr_data = 16'hBEEF;
    bus.rd_enable = 1; bus.rd_addr = 24'h000050;
    tick();
    bus.wr_enable = 0; bus.rd_enable = 0;
    tick();
    chk("t3.first_we",   32'(bus.cmd_we),   32'd1);
    chk("t3.first_addr", 32'(bus.cmd_addr), 32'h40);
    tick();
    chk("t3.gap", 32'(bus.cmd_valid), 32'd0);
    tick();
    chk("t3.second_valid", 32'(bus.cmd_valid), 32'd1);
    chk("t3.second_we",    32'(bus.cmd_we),    32'd0);
    chk("t3.second_addr",  32'(bus.cmd_addr),  32'h50);
    tick();
    chk("t3.overrun", 32'(bus.overrun), 32'd0);
    bus.rsp_valid = 1; bus.rsp_data = 16'h0BAD;
    tick();
    bus.rsp_valid = 0;
    bus.rd_data_ack = 1;
    tick();
    bus.rd_data_ack = 0;

    // 4: stalled controller, second write dropped
    bus.cmd_ready = 0;
    bus.wr_enable = 1; bus.wr_addr = 24'h000070; bus.wr_data = 16'h7777;
    tick();
    bus.wr_enable = 0;
    tick();
    chk("t4.valid", 32'(bus.cmd_valid), 32'd1);
    repeat (3) tick();
    bus.wr_enable = 1; bus.wr_addr = 24'h000071; bus.wr_data = 16'h7171;
    tick();
    bus.wr_enable = 0;
    chk("t4.overrun", 32'(bus.overrun),   32'd1);
    chk("t4.addr",    32'(bus.cmd_addr),  32'h70);
    chk("t4.wdata",   32'(bus.cmd_wdata), 32'h7777);
`ifdef DREC_ARB_STATS_EN
    chk("t4.wr_drop_cnt", 32'(wr_drop_cnt), 32'd1);
`endif
    repeat (4) tick();
    chk("t4.still_valid", 32'(bus.cmd_valid), 32'd1);
    bus.cmd_ready = 1;
    tick();
    tick();
    chk("t4.drained", 32'(bus.cmd_valid), 32'd0);

    // 5: read timeout after RD_TMO cycles in WAIT_RD
    bus.rd_enable = 1; bus.rd_addr = 24'h000080;
    tick();
    bus.rd_enable = 0;
    tick();
    chk("t5.rd_valid", 32'(bus.cmd_valid), 32'd1);
    tick();
    repeat (254) tick();
    chk("t5.no_tmo_yet", 32'(bus.rd_timeout), 32'd0);
    tick();
    chk("t5.tmo", 32'(bus.rd_timeout),  32'd1);
    chk("t5.rdy", 32'(bus.rd_data_rdy), 32'd0);
`ifdef DREC_ARB_STATS_EN
    chk("t5.tmo_cnt", 32'(tmo_cnt), 32'd1);
`endif
    bus.wr_enable = 1; bus.wr_addr = 24'h000090; bus.wr_data = 16'h9090;
    tick();
    bus.wr_enable = 0;
    tick();
    chk("t5.wr_valid", 32'(bus.cmd_valid), 32'd1);
    chk("t5.wr_we",    32'(bus.cmd_we),    32'd1);
    chk("t5.wr_addr",  32'(bus.cmd_addr),  32'h90);
    tick();

    // 6: reset while waiting for a response; late response ignored
    bus.rd_enable = 1; bus.rd_addr = 24'h0000A0;
    tick();
    bus.rd_enable = 0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_quiet("t6.reset");
`ifdef DREC_ARB_STATS_EN
    chk("t6.wr_drop_cnt", 32'(wr_drop_cnt), 32'd0);
    chk("t6.tmo_cnt",     32'(tmo_cnt),     32'd0);
`endif
    rst_n = 1'b1;
    bus.rsp_valid = 1; bus.rsp_data = 16'hDEAD;
    tick();
    bus.rsp_valid = 0;
    chk("t6.late_rdy",  32'(bus.rd_data_rdy), 32'd0);
    chk("t6.late_data", 32'(bus.rd_data),     32'd0);
    tick();
    chk("t6.idle", 32'(bus.cmd_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
